// File: rtl/lemming_pkg.sv
// Shared types and defaults for the lemming terrain/position model.
package lemming_pkg;

    localparam int LEM_WIDTH       = 16;
    localparam int LEM_DIRT_W      = 3;
    localparam int LEM_DROP_W      = 5;
    localparam int LEM_STEP_CYCLES = 4;
    localparam int LEM_DIG_CYCLES  = 8;

    typedef struct packed {
        logic                  wall;
        logic [LEM_DIRT_W-1:0] dirt;
        logic [LEM_DROP_W-1:0] drop;
    } column_t;

    localparam column_t COLUMN_RESET = '{wall: 1'b0, dirt: LEM_DIRT_W'(1), drop: '0};

    typedef enum logic [2:0] {IDLE, WALKL, WALKR, DIG, FALL} action_t;

    // Counter must hold STEP_CYCLES-1, DIG_CYCLES-1 and the fall saturation value.
    function automatic int timer_width(int step_cycles, int dig_cycles, int drop_w);
        int w;
        w = drop_w;
        if ($clog2(step_cycles) > w) w = $clog2(step_cycles);
        if ($clog2(dig_cycles) > w)  w = $clog2(dig_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lemming_action_timer.sv
// Decodes the FSM activity into one action and runs the shared pacing counter.
module lemming_action_timer
    import lemming_pkg::*;
#(
    parameter int STEP_CYCLES = LEM_STEP_CYCLES,
    parameter int DIG_CYCLES  = LEM_DIG_CYCLES,
    parameter int DROP_W      = LEM_DROP_W,
    parameter int TW          = timer_width(LEM_STEP_CYCLES, LEM_DIG_CYCLES, LEM_DROP_W)
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    output action_t       action,
    output logic [TW-1:0] count,
    output logic          step_tc,
    output logic          dig_tc
);

    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] DIG_LAST  = TW'(DIG_CYCLES - 1);
    localparam logic [TW-1:0] FALL_MAX  = TW'((1 << DROP_W) - 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    action_t       prev_action;
    logic          fall_sat;

    always_comb begin
        action = IDLE;
        if (aaah)
            action = FALL;
        else if (digging)
            action = DIG;
        else if (walk_left && !walk_right)
            action = WALKL;
        else if (walk_right && !walk_left)
            action = WALKR;
    end

    // A change of action restarts the count in the same cycle it is seen.
    always_comb begin
        count    = (action != prev_action) ? '0 : timer;
        step_tc  = (count == STEP_LAST);
        dig_tc   = (count == DIG_LAST);
        fall_sat = (count == FALL_MAX);
    end

    always_comb begin
        timer_nxt = '0;
        case (action)
            WALKL, WALKR: timer_nxt = step_tc  ? '0    : count + 1'b1;
            DIG:          timer_nxt = dig_tc   ? '0    : count + 1'b1;
            FALL:         timer_nxt = fall_sat ? count : count + 1'b1;
            default:      timer_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            timer       <= '0;
            prev_action <= IDLE;
        end else begin
            timer       <= timer_nxt;
            prev_action <= action;
        end
    end

endmodule

// File: rtl/lemming_world.sv
// Terrain row and lemming position; converts FSM activity into bump/ground feedback.
module lemming_world
    import lemming_pkg::*;
#(
    parameter  int WIDTH       = LEM_WIDTH,
    parameter  int DIRT_W      = LEM_DIRT_W,
    parameter  int DROP_W      = LEM_DROP_W,
    parameter  int STEP_CYCLES = LEM_STEP_CYCLES,
    parameter  int DIG_CYCLES  = LEM_DIG_CYCLES,
    localparam int POS_W       = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              walk_left,
    input  logic              walk_right,
    input  logic              aaah,
    input  logic              digging,
    input  logic              cfg_we,
    input  logic [POS_W-1:0]  cfg_col,
    input  logic              cfg_wall,
    input  logic [DIRT_W-1:0] cfg_dirt,
    input  logic [DROP_W-1:0] cfg_drop,
    output logic              bump_left,
    output logic              bump_right,
    output logic              ground,
    output logic [POS_W-1:0]  pos
);

    localparam int TW = timer_width(STEP_CYCLES, DIG_CYCLES, DROP_W);

    column_t       terrain [WIDTH];
    logic          landed;
    action_t       action;
    logic [TW-1:0] count;
    logic          step_tc;
    logic          dig_tc;

    logic             walk_tc;
    logic             at_left;
    logic             at_right;
    logic [POS_W-1:0] pos_left;
    logic [POS_W-1:0] pos_right;
    logic             blocked;
    logic [POS_W-1:0] target;
    logic             cfg_ok;
    logic             dig_tc_here;
    logic             land_now;

    lemming_action_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .DIG_CYCLES  (DIG_CYCLES),
        .DROP_W      (DROP_W),
        .TW          (TW)
    ) u_timer (
        .clk        (clk),
        .areset_n   (areset_n),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .action     (action),
        .count      (count),
        .step_tc    (step_tc),
        .dig_tc     (dig_tc)
    );

    // Neighbour indices may wrap at the row ends; the edge flags mask those reads.
    always_comb begin
        at_left   = (pos == '0);
        at_right  = (pos == POS_W'(WIDTH - 1));
        pos_left  = pos - POS_W'(1);
        pos_right = pos + POS_W'(1);
        walk_tc   = ((action == WALKL) || (action == WALKR)) && step_tc;
        if (action == WALKL) begin
            target  = pos_left;
            blocked = at_left || terrain[pos_left].wall;
        end else begin
            target  = pos_right;
            blocked = at_right || terrain[pos_right].wall;
        end
        cfg_ok      = cfg_we && ({1'b0, cfg_col} < (POS_W + 1)'(WIDTH));
        dig_tc_here = (action == DIG) && dig_tc && (terrain[pos].dirt != '0);
        land_now    = (action == FALL) && !landed && (count == TW'(terrain[pos].drop));
        ground      = (terrain[pos].dirt != '0) || landed;
    end

    // The cfg write is issued last so it overrides a same-column dig decrement.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < WIDTH; i++)
                terrain[i] <= COLUMN_RESET;
        end else begin
            if (dig_tc_here)
                terrain[pos].dirt <= terrain[pos].dirt - 1'b1;
            if (cfg_ok)
                terrain[cfg_col] <= '{wall: cfg_wall, dirt: cfg_dirt, drop: cfg_drop};
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos        <= '0;
            landed     <= 1'b0;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
        end else begin
            bump_left  <= walk_tc && blocked && (action == WALKL);
            bump_right <= walk_tc && blocked && (action == WALKR);
            if (walk_tc && !blocked) begin
                pos    <= target;
                landed <= 1'b0;
            end else if (land_now) begin
                landed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: walk, bump, fall, dig, cfg override and async reset.
module tb_lemming_world;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       walk_left, walk_right, aaah, digging;
    logic       cfg_we;
    logic [3:0] cfg_col;
    logic       cfg_wall;
    logic [2:0] cfg_dirt;
    logic [4:0] cfg_drop;
    logic       bump_left, bump_right, ground;
    logic [3:0] pos;

    int checks = 0;
    int errors = 0;

    lemming_world #(
        .WIDTH       (16),
        .DIRT_W      (3),
        .DROP_W      (5),
        .STEP_CYCLES (4),
        .DIG_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .cfg_we     (cfg_we),
        .cfg_col    (cfg_col),
        .cfg_wall   (cfg_wall),
        .cfg_dirt   (cfg_dirt),
        .cfg_drop   (cfg_drop),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cfg(input logic [3:0] col, input logic wall, input logic [2:0] dirt,
                       input logic [4:0] drop);
        cfg_we   = 1'b1;
        cfg_col  = col;
        cfg_wall = wall;
        cfg_dirt = dirt;
        cfg_drop = drop;
    endtask

    initial begin
        areset_n = 1'b0;
        walk_left = 0; walk_right = 0; aaah = 0; digging = 0;
        cfg_we = 0; cfg_col = '0; cfg_wall = 0; cfg_dirt = '0; cfg_drop = '0;

        // Reset state
        tick(2);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_ground", 32'(ground), 1);
        chk("rst_bl", 32'(bump_left), 0);
        chk("rst_br", 32'(bump_right), 0);
        areset_n = 1'b1;

        // Walk left from column 0: blocked by row bound
        walk_left = 1;
        tick(3);
        chk("wl_bl_early", 32'(bump_left), 0);
        tick(1);
        chk("wl_bl_pulse", 32'(bump_left), 1);
        chk("wl_pos", 32'(pos), 0);
        tick(1);
        chk("wl_bl_end", 32'(bump_left), 0);
        walk_left = 0;

        // Wall at column 3, walk right from 0
        cfg(4'd3, 1'b1, 3'd1, 5'd0);
        tick(1);
        cfg_we = 0;
        walk_right = 1;
        tick(3);
        chk("wr_pos0", 32'(pos), 0);
        tick(1);
        chk("wr_pos1", 32'(pos), 1);
        tick(3);
        chk("wr_pos1b", 32'(pos), 1);
        tick(1);
        chk("wr_pos2", 32'(pos), 2);
        tick(3);
        chk("wr_br_early", 32'(bump_right), 0);
        tick(1);
        chk("wr_br_pulse", 32'(bump_right), 1);
        chk("wr_pos_hold", 32'(pos), 2);
        tick(1);
        chk("wr_br_end", 32'(bump_right), 0);
        walk_right = 0;

        // Pit at column 1 with drop 5: walk in, fall, land 6 cycles later
        cfg(4'd1, 1'b0, 3'd0, 5'd5);
        tick(1);
        cfg_we = 0;
        walk_left = 1;
        tick(4);
        walk_left = 0;
        aaah = 1;
        chk("pit_pos", 32'(pos), 1);
        chk("pit_ground", 32'(ground), 0);
        chk("pit_bl", 32'(bump_left), 0);
        tick(5);
        chk("fall5_ground", 32'(ground), 0);
        tick(1);
        chk("fall6_ground", 32'(ground), 1);
        aaah = 0;

        // Dig through two layers at column 2, then fall with drop 25
        cfg(4'd2, 1'b0, 3'd2, 5'd25);
        tick(1);
        cfg_we = 0;
        walk_right = 1;
        tick(4);
        walk_right = 0;
        digging = 1;
        chk("dig_pos", 32'(pos), 2);
        chk("dig_ground0", 32'(ground), 1);
        tick(8);
        chk("dig8_ground", 32'(ground), 1);
        tick(7);
        chk("dig15_ground", 32'(ground), 1);
        tick(1);
        chk("dig16_ground", 32'(ground), 0);
        digging = 0;
        aaah = 1;
        tick(21);
        chk("deep21_ground", 32'(ground), 0);
        tick(4);
        chk("deep25_ground", 32'(ground), 0);
        tick(1);
        chk("deep26_ground", 32'(ground), 1);
        aaah = 0;

        // Back into the pit; cfg on current column overrides a same-edge dig decrement
        walk_left = 1;
        tick(4);
        walk_left = 0;
        chk("ovr_pos", 32'(pos), 1);
        chk("ovr_ground0", 32'(ground), 0);
        cfg(4'd1, 1'b0, 3'd1, 5'd5);
        tick(1);
        cfg_we = 0;
        chk("cfg_next_ground", 32'(ground), 1);
        digging = 1;
        tick(7);
        chk("ovr_pre_ground", 32'(ground), 1);
        cfg(4'd1, 1'b0, 3'd3, 5'd5);
        tick(1);
        cfg_we = 0;
        chk("ovr_ground", 32'(ground), 1);
        tick(8);
        chk("ovr_d2_ground", 32'(ground), 1);
        tick(8);
        chk("ovr_d1_ground", 32'(ground), 1);
        tick(7);
        chk("ovr_d1b_ground", 32'(ground), 1);
        tick(1);
        chk("ovr_d0_ground", 32'(ground), 0);
        digging = 0;

        // Both walk outputs high: treated as idle
        walk_left = 1;
        walk_right = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("both_bl", 32'(bump_left), 0);
            chk("both_br", 32'(bump_right), 0);
        end
        chk("both_pos", 32'(pos), 1);

        // Asynchronous reset mid-walk
        walk_left = 0;
        tick(2);
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_pos", 32'(pos), 0);
        chk("arst_ground", 32'(ground), 1);
        chk("arst_bl", 32'(bump_left), 0);
        chk("arst_br", 32'(bump_right), 0);
        tick(3);
        chk("arst_hold_pos", 32'(pos), 0);
        areset_n = 1'b1;

        // Terrain restored: column 1 solid, wall at 3 gone, right bound blocks at 15
        tick(3);
        chk("post_pos0", 32'(pos), 0);
        tick(1);
        chk("post_pos1", 32'(pos), 1);
        chk("post_ground1", 32'(ground), 1);
        tick(8);
        chk("post_pos3", 32'(pos), 3);
        tick(48);
        chk("post_pos15", 32'(pos), 15);
        tick(3);
        chk("edge_br_early", 32'(bump_right), 0);
        tick(1);
        chk("edge_br_pulse", 32'(bump_right), 1);
        chk("edge_pos", 32'(pos), 15);
        walk_right = 0;
        tick(1);
        chk("edge_br_end", 32'(bump_right), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
